// File: rtl/ahb_dma_master.sv
// ahb_dma_master: single-channel AHB-Lite word copier (src -> dst), one transfer
// outstanding. Optional feature macro: AHB_DMA_FIXED_SRC_EN (adds src_fixed).
// Ports: clk/resetn; start/src_addr/dst_addr/len[/src_fixed] request;
//        busy/done/err/err_addr status; ahb_*_o / ahb_*_i AHB-Lite master port.
module ahb_dma_master #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
`ifdef AHB_DMA_FIXED_SRC_EN
  input  logic             src_fixed,
`endif
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      err_addr,
  output logic [31:0]      ahb_haddr_o,
  output logic             ahb_hwrite_o,
  output logic [2:0]       ahb_hsize_o,
  output logic [2:0]       ahb_hburst_o,
  output logic [3:0]       ahb_hprot_o,
  output logic [1:0]       ahb_htrans_o,
  output logic             ahb_hmastlock_o,
  output logic [31:0]      ahb_hwdata_o,
  input  logic             ahb_hready_i,
  input  logic             ahb_hresp_i,
  input  logic [31:0]      ahb_hrdata_i
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_ADDR = 3'd3;
  localparam logic [2:0] S_WR_DATA = 3'd4;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  logic [2:0]       state;
  logic [31:0]      cur_src;
  logic [31:0]      cur_dst;
  logic [LEN_W-1:0] remaining;
  logic [31:0]      data_q;
  logic [31:0]      next_src;
  logic [31:0]      next_dst;

  assign ahb_hsize_o     = 3'b010;
  assign ahb_hburst_o    = 3'b000;
  assign ahb_hprot_o     = 4'b0011;
  assign ahb_hmastlock_o = 1'b0;

  assign next_dst = cur_dst + 32'd4;

`ifdef AHB_DMA_FIXED_SRC_EN
  logic fixed_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      fixed_q <= 1'b0;
    else if (state == S_IDLE && start)
      fixed_q <= src_fixed;
  end

  assign next_src = fixed_q ? cur_src : cur_src + 32'd4;
`else
  assign next_src = cur_src + 32'd4;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      cur_src      <= '0;
      cur_dst      <= '0;
      remaining    <= '0;
      data_q       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_addr     <= '0;
      ahb_haddr_o  <= '0;
      ahb_hwrite_o <= 1'b0;
      ahb_htrans_o <= HT_IDLE;
      ahb_hwdata_o <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            err_addr <= '0;
            if (len != '0) begin
              // Low address bits are dropped: word transfers only.
              cur_src      <= src_addr & ~32'd3;
              cur_dst      <= dst_addr & ~32'd3;
              remaining    <= len;
              busy         <= 1'b1;
              ahb_haddr_o  <= src_addr & ~32'd3;
              ahb_hwrite_o <= 1'b0;
              ahb_htrans_o <= HT_NONSEQ;
              state        <= S_RD_ADDR;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_RD_ADDR: begin
          if (ahb_hready_i) begin
            ahb_htrans_o <= HT_IDLE;
            state        <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (ahb_hready_i) begin
            if (ahb_hresp_i) begin
              err          <= 1'b1;
              err_addr     <= ahb_haddr_o;
              busy         <= 1'b0;
              ahb_hwrite_o <= 1'b0;
              state        <= S_IDLE;
            end else begin
              data_q       <= ahb_hrdata_i;
              ahb_haddr_o  <= cur_dst;
              ahb_hwrite_o <= 1'b1;
              ahb_htrans_o <= HT_NONSEQ;
              state        <= S_WR_ADDR;
            end
          end
        end
        S_WR_ADDR: begin
          if (ahb_hready_i) begin
            ahb_htrans_o <= HT_IDLE;
            ahb_hwdata_o <= data_q;
            state        <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (ahb_hready_i) begin
            if (ahb_hresp_i) begin
              err          <= 1'b1;
              err_addr     <= ahb_haddr_o;
              busy         <= 1'b0;
              ahb_hwrite_o <= 1'b0;
              state        <= S_IDLE;
            end else begin
              remaining <= remaining - ONE;
              cur_src   <= next_src;
              cur_dst   <= next_dst;
              if (remaining == ONE) begin
                done         <= 1'b1;
                busy         <= 1'b0;
                ahb_hwrite_o <= 1'b0;
                state        <= S_IDLE;
              end else begin
                ahb_haddr_o  <= next_src;
                ahb_hwrite_o <= 1'b0;
                ahb_htrans_o <= HT_NONSEQ;
                state        <= S_RD_ADDR;
              end
            end
          end
        end
        default: begin
          ahb_htrans_o <= HT_IDLE;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ahb_dma_master.md
# ahb_dma_master

Single-channel AHB-Lite initiator that copies a block of 32-bit words from a source address range to a destination address range over the SoC AHB fabric. It sits beside the CPU as a second bus master, moving camera pixel words from the camera unit into NPU input memory without CPU load/store loops. Control is a start/busy/done sideband, and bus signalling matches the CPU master port so it can feed an interconnect slave port directly.

## Interface
- LEN_W, 16, width of the word-count input; max transfer is 2^LEN_W-1 words
- clk  in  1  system clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- src_addr  in  32  source byte address; bits [1:0] ignored (forced 0)
- dst_addr  in  32  destination byte address; bits [1:0] ignored
- len  in  LEN_W  number of words to copy
- src_fixed  in  1  hold source address constant (present only with AHB_DMA_FIXED_SRC_EN)
- busy  out  1  high from the cycle after an accepted start until done/err
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on HRESP error abort
- err_addr  out  32  haddr of the failing transfer; held until next start
- ahb_haddr_o  out  32  address
- ahb_hwrite_o  out  1  1 = write
- ahb_hsize_o  out  3  constant 3'b010 (word)
- ahb_hburst_o  out  3  constant 3'b000 (SINGLE)
- ahb_hprot_o  out  4  constant 4'b0011
- ahb_htrans_o  out  2  IDLE 2'b00 / NONSEQ 2'b10 only
- ahb_hmastlock_o  out  1  constant 0
- ahb_hwdata_o  out  32  write data, valid in write data phase
- ahb_hready_i  in  1  transfer-complete / bus ready
- ahb_hresp_i  in  1  1 = ERROR
- ahb_hrdata_i  in  32  read data

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA.
- IDLE: start=1 with len!=0 → latch src, dst, len (and src_fixed); go RD_ADDR. start=1 with len==0 → done pulse next cycle, busy stays 0. start while busy is ignored.
- RD_ADDR: drive htrans=NONSEQ, hwrite=0, haddr=cur_src. When hready=1 → RD_DATA.
- RD_DATA: htrans=IDLE. When hready=1, hresp=0 → capture hrdata into data register, go WR_ADDR.
- WR_ADDR: htrans=NONSEQ, hwrite=1, haddr=cur_dst. When hready=1 → WR_DATA.
- WR_DATA: htrans=IDLE, hwdata=data register. When hready=1, hresp=0 → decrement remaining count, cur_dst+=4, cur_src+=4 (unless fixed); remaining==1 before decrement → IDLE with done pulse, else RD_ADDR.
- Error: in RD_DATA/WR_DATA, hresp=1 (either cycle of the two-cycle response) → htrans held IDLE; on hready=1 with hresp=1 → err pulse, err_addr = address of that transfer, → IDLE, no further transfers. Destination word of a failed read is not written.
- Address arithmetic modulo 2^32; 0xFFFF_FFFC + 4 wraps to 0x0000_0000 without error.
- Only one transfer outstanding; no address/data phase overlap.

## Timing
- Reset values: haddr 0, hwrite 0, htrans IDLE, hwdata 0, busy 0, done 0, err 0, err_addr 0; constants as listed. FSM → IDLE.
- Start accepted in cycle T → NONSEQ read address on bus at T+1.
- Zero wait states: 4 cycles per word; len=N completes with done at T+1+4N, busy falls same cycle as done.
- Each hready=0 cycle adds exactly one cycle in the current state; outputs held stable while hready=0.
- All outputs registered. Reset asserted mid-transfer returns to IDLE immediately, htrans IDLE; no done/err.

## Configuration
- AHB_DMA_FIXED_SRC_EN defined: src_fixed port exists; when latched high, every read uses the start src_addr (peripheral data register). Undefined: port absent, source always increments by 4.

## Test plan
- Reset: hold resetn=0 → htrans=2'b00, busy=0, done=0, err=0, haddr=0.
- Basic copy: src=0x100, dst=0x2000, len=3, zero-wait slave → reads 0x100/0x104/0x108, writes 0x2000/0x2004/0x2008 with matching data, done at T+13.
- Wait states: slave inserts 2 wait cycles on every data phase, len=2 → correct data, done at T+1+8+8=T+17, haddr/hwdata stable during waits.
- Error: second read returns two-cycle ERROR, len=4 → one write only, err pulse, err_addr=src+4, no done, htrans IDLE after.
- Edge cases: len=0 → done next cycle, no NONSEQ; dst=0xFFFF_FFFC, len=2 → writes 0xFFFF_FFFC then 0x0; start during busy ignored.
- With AHB_DMA_FIXED_SRC_EN, src_fixed=1, src=0x40, len=4 → four reads all at 0x40, writes increment.
